// File: rtl/seq_multiplier.sv
// Sequential shift-and-add multiplier, unsigned or radix-2 Booth signed,
// one partial-product iteration per clock with an internal start/done FSM.
module seq_multiplier #(
    parameter int BITS  = 8,
    parameter int CNT_W = $clog2(BITS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                signed_mode,
    input  logic [BITS-1:0]     multiplicand,
    input  logic [BITS-1:0]     multiplier,
    output logic                busy,
    output logic                done,
    output logic [2*BITS-1:0]   product,
    output logic [CNT_W-1:0]    count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [BITS:0]   a;
    logic [BITS-1:0] q;
    logic            q_m1;
    logic [BITS:0]   b;
    logic            mode;

    logic [BITS:0]   acc;
    logic [BITS:0]   a_nx;
    logic [BITS-1:0] q_nx;

    // Guard bit in A keeps the Booth sum exact even for B = -2^(BITS-1).
    always_comb begin
        acc = a;
        if (mode) begin
            unique case ({q[0], q_m1})
                2'b01:   acc = a + b;
                2'b10:   acc = a - b;
                default: acc = a;
            endcase
        end else if (q[0]) begin
            acc = a + b;
        end
        a_nx = {mode & acc[BITS], acc[BITS:1]};
        q_nx = {acc[0], q[BITS-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            a       <= '0;
            q       <= '0;
            q_m1    <= 1'b0;
            b       <= '0;
            mode    <= 1'b0;
            count   <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        b     <= {signed_mode & multiplicand[BITS-1],
                                  multiplicand};
                        q     <= multiplier;
                        a     <= '0;
                        q_m1  <= 1'b0;
                        count <= CNT_W'(BITS);
                        mode  <= signed_mode;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                CALC: begin
                    a     <= a_nx;
                    q     <= q_nx;
                    q_m1  <= q[0];
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        product <= {a_nx[BITS-1:0], q_nx};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: 8-bit and 16-bit instances,
// hand-computed vectors plus a 16-bit sweep against an integer model.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start8 = 1'b0;
    logic        sm8 = 1'b0;
    logic [7:0]  mc8 = '0;
    logic [7:0]  mp8 = '0;
    logic        busy8;
    logic        done8;
    logic [15:0] prod8;
    logic [3:0]  cnt8;

    logic        start16 = 1'b0;
    logic        sm16 = 1'b0;
    logic [15:0] mc16 = '0;
    logic [15:0] mp16 = '0;
    logic        busy16;
    logic        done16;
    logic [31:0] prod16;
    logic [4:0]  cnt16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.BITS(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .multiplicand(mc8), .multiplier(mp8),
        .busy(busy8), .done(done8), .product(prod8), .count(cnt8)
    );

    seq_multiplier #(.BITS(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .multiplicand(mc16), .multiplier(mp16),
        .busy(busy16), .done(done16), .product(prod16), .count(cnt16)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic sm, input logic [7:0] b,
                        input logic [7:0] q, input logic [15:0] exp,
                        input string tag);
        int edge_n;
        int busy_n;
        @(negedge clk);
        start8 = 1'b1; sm8 = sm; mc8 = b; mp8 = q;
        @(posedge clk); #1;
        start8 = 1'b0; sm8 = ~sm;
        mc8 = 8'($urandom); mp8 = 8'($urandom);
        edge_n = 0;
        busy_n = busy8 ? 1 : 0;
        while (!done8 && edge_n < 40) begin
            @(posedge clk); #1;
            edge_n++;
            if (busy8) busy_n++;
        end
        chk({tag, "_lat"}, 32'(edge_n), 32'd8);
        chk({tag, "_busy"}, 32'(busy_n), 32'd8);
        chk({tag, "_prod"}, 32'(prod8), 32'(exp));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(done8), 32'd0);
    endtask

    task automatic run16(input logic sm, input logic [15:0] b,
                         input logic [15:0] q, input logic [31:0] exp,
                         input string tag);
        int edge_n;
        @(negedge clk);
        start16 = 1'b1; sm16 = sm; mc16 = b; mp16 = q;
        @(posedge clk); #1;
        start16 = 1'b0; mc16 = 16'($urandom); mp16 = 16'($urandom);
        edge_n = 0;
        while (!done16 && edge_n < 60) begin
            @(posedge clk); #1;
            edge_n++;
        end
        chk({tag, "_lat"}, 32'(edge_n), 32'd16);
        chk({tag, "_prod"}, prod16, exp);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rs;
        longint      ref_p;
        int          edge_n;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_prod", 32'(prod8), 32'd0);
        chk("rst_cnt", 32'(cnt8), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run8(1'b0, 8'hFF, 8'hFF, 16'hFE01, "u255x255");
        run8(1'b1, 8'h80, 8'h80, 16'h4000, "s_m128sq");
        run8(1'b1, 8'h80, 8'h7F, 16'hC080, "s_m128x127");
        run8(1'b1, 8'h05, 8'hFD, 16'hFFF1, "s_5xm3");
        run8(1'b0, 8'h80, 8'h80, 16'h4000, "u80x80");
        run8(1'b0, 8'h00, 8'hFF, 16'h0000, "u_zero");
        run8(1'b1, 8'h00, 8'hFF, 16'h0000, "s_zero");

        // start held high across two operations
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'd12; mp8 = 8'd11;
        @(posedge clk); #1;
        chk("hold_busy0", 32'(busy8), 32'd1);
        chk("hold_cnt0", 32'(cnt8), 32'd8);
        mc8 = 8'($urandom); mp8 = 8'($urandom); sm8 = 1'b1;
        repeat (7) begin
            @(posedge clk); #1;
            mc8 = 8'($urandom); mp8 = 8'($urandom);
        end
        @(posedge clk); #1;
        chk("hold_done", 32'(done8), 32'd1);
        chk("hold_prod", 32'(prod8), 32'h0084);
        mc8 = 8'd3; mp8 = 8'd5; sm8 = 1'b0;
        @(posedge clk); #1;
        chk("hold_nodone_accept", 32'(busy8), 32'd0);
        chk("hold_done_drop", 32'(done8), 32'd0);
        @(posedge clk); #1;
        chk("hold_accept", 32'(busy8), 32'd1);
        chk("hold_cnt", 32'(cnt8), 32'd8);
        chk("hold_prod_kept", 32'(prod8), 32'h0084);
        start8 = 1'b0;
        edge_n = 0;
        while (!done8 && edge_n < 40) begin
            @(posedge clk); #1;
            edge_n++;
        end
        chk("hold2_lat", 32'(edge_n), 32'd8);
        chk("hold2_prod", 32'(prod8), 32'h000F);
        @(posedge clk); #1;

        // reset in the middle of an operation
        @(negedge clk);
        start8 = 1'b1; sm8 = 1'b0; mc8 = 8'd7; mp8 = 8'd9;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy8), 32'd1);
        chk("mid_cnt", 32'(cnt8), 32'd4);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_prod", 32'(prod8), 32'd0);
        chk("abort_cnt", 32'(cnt8), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_nodone", 32'(done8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run8(1'b0, 8'd7, 8'd9, 16'h003F, "u7x9");

        // 16-bit instance
        run16(1'b1, 16'h8000, 16'h8000, 32'h40000000, "w_s_min_sq");
        run16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w_u_max_sq");
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rs = i[0];
            if (rs)
                ref_p = longint'($signed(ra)) * longint'($signed(rb));
            else
                ref_p = longint'(ra) * longint'(rb);
            run16(rs, ra, rb, ref_p[31:0], "w_sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Parametrised sequential shift-and-add multiplier with its own control FSM and start/done handshake.
- Supports unsigned mode and signed mode (radix-2 Booth); one partial-product iteration per clock.
- Next-generation multiplier core for the datapath; replaces externally sequenced load/add/shift strobes with an internal FSM.

Parameters:
- BITS, 8, operand width; legal range BITS >= 2.
- CNT_W, $clog2(BITS+1), iteration counter width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- signed_mode  input  1  0 = unsigned, 1 = two's-complement signed; latched with operands.
- multiplicand  input  BITS  operand B; latched on accepted start.
- multiplier  input  BITS  operand Q; latched on accepted start.
- busy  output  1  high while in CALC.
- done  output  1  one-cycle pulse; product valid in that cycle and afterwards.
- product  output  2*BITS  registered result; held until the next completion.
- count  output  CNT_W  remaining iterations; debug/observation.

Behaviour:
- Reset (async, rst=1): state=IDLE; A, Q, Q_m1, B, mode, count, product = 0; busy=0; done=0.
- Internal registers:
  - A: BITS+1 bits, extended accumulator.
  - Q: BITS bits.
  - Q_m1: 1 bit, Booth history.
  - B: BITS+1 bits.
  - mode: 1 bit.
- IDLE:
  - On start=1 at an edge, latch the operands.
  - B = zero-extended multiplicand (unsigned) or sign-extended multiplicand (signed).
  - Q = multiplier; A = 0; Q_m1 = 0; count = BITS; mode = signed_mode.
  - Go to CALC.
  - start=0: remain in IDLE.
- CALC, one iteration per edge:
  - Unsigned: if Q[0]=1, A = A+B. Then shift {A,Q} right by 1, inserting 0 at the MSB.
  - Signed: {Q[0],Q_m1}=01 gives A = A+B; 10 gives A = A-B; 00 or 11 leaves A unchanged. Then arithmetic shift {A,Q,Q_m1} right by 1, replicating A[BITS].
  - All arithmetic is BITS+1 wide, modulo 2^(BITS+1). No overflow is possible, including B = -2^(BITS-1).
  - count decrements each iteration.
  - On the edge where count goes 1 -> 0: product = {A[BITS-1:0],Q} (post-shift value); state -> DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next edge -> IDLE unconditionally.
  - start asserted in DONE is ignored; it must be re-asserted in IDLE.
- Latency:
  - Start-sampling edge = edge 0.
  - Iterations occur on edges 1..BITS.
  - done is high in the cycle after edge BITS.
  - Next accepted start is at edge BITS+2 at the earliest.
- busy=1 exactly BITS cycles per operation.
- start, operand, or signed_mode changes during CALC or DONE have no effect.
- Signed results are exact two's-complement 2*BITS-bit products. Unsigned results are exact 2*BITS-bit products.
- Reset asserted mid-CALC aborts immediately to reset values. No done pulse is issued, and the previous product is cleared to 0.
- product changes only on entry to DONE or on reset.
- Fully synchronous except for the reset. No combinational path from inputs to outputs.

Test Plan:
- Reset then BITS=8 unsigned 255 x 255 -> done after 8 edges past start edge, product=0xFE01, busy high exactly 8 cycles.
- Signed -128 x -128 (0x80,0x80) -> product=0x4000; signed -128 x 127 -> product=0xC080; signed 5 x -3 -> product=0xFFF1.
- Unsigned 0x80 x 0x80 -> 0x4000; zero operand (0 x 0xFF, either mode) -> product=0, done still pulses after 8 iterations.
- start held high continuously over two operations -> second operation accepted only in IDLE (edge BITS+2), never from DONE; operands toggled during CALC do not change result (e.g. 12x11=0x0084).
- rst asserted at iteration 4 of 7x9 -> outputs immediately 0, state IDLE, no done; next start 7x9 -> 0x003F normal latency.
- Rebuild with BITS=16: signed 0x8000 x 0x8000 -> 0x40000000; unsigned 0xFFFF x 0xFFFF -> 0xFFFE0001, done after 16 iterations; random self-checking sweep against a reference model in both modes.
